fetch_queue: RTL and testbench

Small ready/valid FIFO that buffers instruction words between the fetch stage and `decode_fsm`, decoupling memory-side latency from decode stalls. Fetch pushes words as they arrive; decode pops one word per cycle when its FSM accepts it. A flush input discards all buffered words on branch or exception redirect. There is no combinational path from input to output, so every word spends at least one cycle in the queue.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/queue_ptr.sv | 42 ++++
 rtl/fetch_queue.sv | 93 +++++++++
 tb/tb_fetch_queue.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Types and constants shared by the fetch queue and decode stage.
//            instr_word_t      - one instruction word (16 bits)
//            FETCH_QUEUE_DEPTH - number of entries in the fetch queue
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef logic [15:0] instr_word_t;

    localparam int FETCH_QUEUE_DEPTH = 4;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/queue_ptr.sv
`default_nettype none
// ============================================================================
// Module   : queue_ptr
// Purpose  : Wrapping queue pointer. The low $clog2(DEPTH) bits index the
//            storage array; the extra MSB is a wrap bit that toggles on each
//            pass, so equal indices with differing wrap bits mean "full".
// Ports    : clk - clock, rising edge
//            rst - synchronous active-high reset, clears pointer
//            inc - advance pointer by one
//            clr - clear pointer to zero (overrides inc)
//            ptr - current pointer value {wrap, index}
// Revision : 1.0 - initial release
// ============================================================================
module queue_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc,
    input  logic                   clr,
    output logic [$clog2(DEPTH):0] ptr
);

    localparam int                c_ptr_w = $clog2(DEPTH) + 1;
    localparam logic [c_ptr_w-1:0] c_one  = c_ptr_w'(1);

    logic [c_ptr_w-1:0] r_ptr;

    // DEPTH is a power of two, so natural binary overflow of the full
    // pointer width gives the index wrap and the wrap-bit toggle together.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + c_one;
        end
    end

    assign ptr = r_ptr;

endmodule : queue_ptr
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Ready/valid FIFO buffering instruction words between fetch and
//            decode. No combinational input-to-output path; flush discards
//            all buffered words at the next edge.
// Ports    : clk       - clock, rising edge
//            rst       - synchronous active-high reset (same effect as flush)
//            flush     - discard all contents at the next edge
//            in_valid  - fetch presents a word
//            in_ready  - queue can accept a word (not full)
//            in_data   - word from fetch
//            out_valid - head word available (not empty)
//            out_ready - decode consumes head word
//            out_data  - head word
//            level     - occupancy, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = $bits(instr_word_t),
    parameter int DEPTH      = FETCH_QUEUE_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_pw = c_aw + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [c_pw-1:0] w_wr_ptr;
    logic [c_pw-1:0] w_rd_ptr;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;

    // Status depends only on the pointer flops, so in_ready never sees
    // out_ready or flush: a pop at full does not open a slot that cycle.
    assign w_empty = (w_wr_ptr == w_rd_ptr);
    assign w_full  = (w_wr_ptr[c_aw-1:0] == w_rd_ptr[c_aw-1:0]) &&
                     (w_wr_ptr[c_aw] != w_rd_ptr[c_aw]);

    assign w_push = in_valid && !w_full;
    assign w_pop  = out_ready && !w_empty;

    queue_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_push),
        .clr (flush),
        .ptr (w_wr_ptr)
    );

    queue_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_pop),
        .clr (flush),
        .ptr (w_rd_ptr)
    );

    // Storage is never cleared; a write during flush/reset is suppressed
    // since the pointer it would have advanced is being zeroed anyway.
    always_ff @(posedge clk) begin
        if (w_push && !flush && !rst) begin
            r_mem[w_wr_ptr[c_aw-1:0]] <= in_data;
        end
    end

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_data  = r_mem[w_rd_ptr[c_aw-1:0]];
    // Modular subtraction across the wrap bit yields occupancy 0..DEPTH.
    assign level     = w_wr_ptr - w_rd_ptr;

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Self-checking bench for fetch_queue. A driver issues stimulus
//            and keeps an occupancy model plus a queue of expected words; a
//            monitor checks status outputs and pops/compares head words on
//            every completed output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int c_dw    = 16;
    localparam int c_depth = 4;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [c_dw-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [c_dw-1:0] out_data;
    logic [2:0]      level;

    fetch_queue #(
        .DATA_WIDTH (c_dw),
        .DEPTH      (c_depth)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: words accepted but not yet consumed, plus occupancy.
    logic [c_dw-1:0] exp_q[$];
    int              model_cnt  = 0;
    bit              p_acc      = 1'b0;
    bit              p_pop      = 1'b0;
    bit              p_clear    = 1'b1;
    bit              rst_seen   = 1'b0;
    bit              armed      = 1'b0;
    int              checks     = 0;
    int              errors     = 0;
    int              max_level  = 0;

    // One cycle of stimulus: first retire the effect of the previous cycle's
    // inputs (which took effect at the edge just passed), then apply new ones.
    task automatic step(input bit iv, input logic [c_dw-1:0] d,
                        input bit ordy, input bit fl, input bit rs);
        @(negedge clk);
        if (p_clear) begin
            if (rst_seen) armed = 1'b1;
            exp_q.delete();
            model_cnt = 0;
        end else begin
            model_cnt = model_cnt + int'(p_acc) - int'(p_pop);
        end
        p_clear = fl || rs;
        p_acc   = iv && !p_clear && (model_cnt < c_depth);
        p_pop   = ordy && !p_clear && (model_cnt > 0);
        if (p_acc) exp_q.push_back(d);
        if (rs) rst_seen = 1'b1;
        rst       = rs;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    // Monitor: samples mid-low-phase, well clear of the rising edge.
    initial begin
        logic [c_dw-1:0] exp_word;
        forever begin
            @(negedge clk);
            #2;
            if (armed) begin
                checks++;
                if (int'(level) != model_cnt) begin
                    errors++;
                    $display("FAIL level: got %0d expected %0d at %0t", level, model_cnt, $time);
                end
                checks++;
                if (in_ready !== (model_cnt < c_depth)) begin
                    errors++;
                    $display("FAIL in_ready: got %b expected %b at %0t", in_ready, (model_cnt < c_depth), $time);
                end
                checks++;
                if (out_valid !== (model_cnt > 0)) begin
                    errors++;
                    $display("FAIL out_valid: got %b expected %b at %0t", out_valid, (model_cnt > 0), $time);
                end
                if (int'(level) > max_level) max_level = int'(level);
                if (out_valid && out_ready && !flush && !rst) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL pop_underflow: got word %h expected none at %0t", out_data, $time);
                    end else begin
                        exp_word = exp_q.pop_front();
                        if (out_data !== exp_word) begin
                            errors++;
                            $display("FAIL out_data: got %h expected %h at %0t", out_data, exp_word, $time);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset
        step(0, 16'h0, 0, 0, 1);
        step(0, 16'h0, 0, 0, 1);
        step(0, 16'h0, 0, 0, 0);

        // Fill to full, then a refused fifth push
        step(1, 16'h1111, 0, 0, 0);
        step(1, 16'h2222, 0, 0, 0);
        step(1, 16'h3333, 0, 0, 0);
        step(1, 16'h4444, 0, 0, 0);
        step(1, 16'h5555, 0, 0, 0);

        // Drain in order
        for (int i = 0; i < 4; i++) step(0, 16'h0, 1, 0, 0);
        step(0, 16'h0, 0, 0, 0);

        // Concurrent push/pop holding level at 2
        step(1, 16'hC000, 0, 0, 0);
        step(1, 16'hC001, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 16'(16'hC100 + i), 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 0, 0);

        // Full plus pop: only the pop happens, push lands the next cycle
        for (int i = 0; i < 4; i++) step(1, 16'(16'hF000 + i), 0, 0, 0);
        step(1, 16'hF0F0, 1, 0, 0);
        step(1, 16'hF0F0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 16'h0, 1, 0, 0);

        // Flush mid-stream with a concurrent push and pop
        step(1, 16'hA001, 0, 0, 0);
        step(1, 16'hA002, 0, 0, 0);
        step(1, 16'hA003, 0, 0, 0);
        step(1, 16'hAAAA, 1, 1, 0);
        step(1, 16'hBBBB, 0, 0, 0);
        step(0, 16'h0, 1, 0, 0);
        step(0, 16'h0, 0, 0, 0);

        // Randomised traffic with stalls on both sides and rare flushes
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) < 6), 16'($urandom()),
                 ($urandom_range(0, 9) < 5), ($urandom_range(0, 59) == 0), 1'b0);
        end

        // Mid-traffic reset
        step(1, 16'h1234, 1, 0, 1);
        for (int i = 0; i < 20; i++) step(1'b1, 16'($urandom()), ($urandom_range(0, 1) == 1), 0, 0);

        // Drain
        for (int i = 0; i < 6; i++) step(0, 16'h0, 1, 0, 0);

        @(negedge clk);
        armed = 1'b0;
        #3;

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: got %0d words left expected 0", exp_q.size());
        end
        checks++;
        if (max_level > c_depth) begin
            errors++;
            $display("FAIL max_level: got %0d expected at most %0d", max_level, c_depth);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_queue
`default_nettype wire
